// File: rtl/mul_pkg.sv
// Shared types and helpers for the Booth multiplier family (sequential and pipelined).
// Latency: none, this file holds declarations only.
// Backpressure: not applicable.
package mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {B_ZERO, B_P1, B_P2, B_M1, B_M2} booth_sel_t;

  // One radix-4 step per bit pair of the (W+2)-bit extended multiplier.
  function automatic int iter_count(input int w);
    return w / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_sel.sv
// Radix-4 Booth recoder: maps a multiplier triplet to 0, +-A or +-2A at accumulator width.
// Latency: purely combinational.
// Backpressure: none; the caller owns the handshakes.
module booth_r4_sel
  import mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   trip,
  input  logic [W+1:0] mcand,
  output logic [W+2:0] addend
);

  booth_sel_t   sel;
  logic [W+2:0] a1;
  logic [W+2:0] a2;

  // +A sign-extended by one bit; +2A fits exactly because mcand already carries two guard bits.
  assign a1 = {mcand[W+1], mcand};
  assign a2 = {mcand, 1'b0};

  // Decode the overlapping bit triplet {b[2i+1], b[2i], b[2i-1]} into a digit in -2..+2.
  always_comb begin
    sel = B_ZERO;
    case (trip)
      3'b001, 3'b010: sel = B_P1;
      3'b011:         sel = B_P2;
      3'b100:         sel = B_M2;
      3'b101, 3'b110: sel = B_M1;
      default:        sel = B_ZERO;
    endcase
  end

  // Produce the addend for the selected digit.
  always_comb begin
    addend = '0;
    case (sel)
      B_P1:    addend = a1;
      B_P2:    addend = a2;
      B_M1:    addend = {(W+3){1'b0}} - a1;
      B_M2:    addend = {(W+3){1'b0}} - a2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/mul_booth_seq.sv
// Iterative radix-4 Booth multiplier, signed or unsigned per transaction, full 2W-bit product.
// Latency: out_valid rises ITER = W/2+1 edges after the accept edge; one product per ITER+2 cycles.
// Backpressure: in_ready only in IDLE; the product is held in DONE until out_ready, clear aborts.
module mul_booth_seq
  import mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_signed,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] mul
);

  localparam int ITER = iter_count(W);
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t         state;
  state_t         state_nxt;
  logic [W+2:0]   acc;
  logic [W+1:0]   mcand;
  logic [W+1:0]   mq;
  logic           bm1;
  logic [CW-1:0]  count;
  logic [W+2:0]   addend;
  logic [W+2:0]   sum;
  logic [W+2:0]   acc_nxt;
  logic [W+1:0]   mq_nxt;
  logic           accept;
  logic           last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready && !clear;
  assign last_step = (state == RUN) && (count == LAST);

  booth_r4_sel #(.W(W)) u_sel (
    .trip   ({mq[1:0], bm1}),
    .mcand  (mcand),
    .addend (addend)
  );

  // One Booth step: add into the upper half, then arithmetic shift {acc, mq, bm1} right by two.
  assign sum     = acc + addend;
  assign acc_nxt = {{2{sum[W+2]}}, sum[W+2:2]};
  assign mq_nxt  = {sum[1:0], mq[W+1:2]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear overrides every handshake.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = RUN;
        RUN:     if (count == LAST) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture and the iterative accumulate/shift datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mq    <= '0;
      bm1   <= 1'b0;
      count <= '0;
    end else if (accept) begin
      acc   <= '0;
      mcand <= in_signed ? {{2{a[W-1]}}, a} : {2'b00, a};
      mq    <= in_signed ? {{2{b[W-1]}}, b} : {2'b00, b};
      bm1   <= 1'b0;
      count <= '0;
    end else if (state == RUN && !clear) begin
      acc   <= acc_nxt;
      mq    <= mq_nxt;
      bm1   <= mq[1];
      count <= count + 1'b1;
    end
  end

  // Output register, loaded on the final step and untouched by clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   mul <= '0;
    else if (last_step && !clear) mul <= {acc_nxt[W-3:0], mq_nxt};
  end

endmodule

// File: tb/tb_mul_booth_seq.sv
module tb_mul_booth_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clear;

  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8;
  logic [7:0]  a8, b8;
  logic [15:0] mul8;

  logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] mul16;

  int n_chk  = 0;
  int n_fail = 0;

  mul_booth_seq #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_signed(in_signed8),
    .a(a8), .b(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .mul(mul8)
  );

  mul_booth_seq #(.W(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_signed(in_signed16),
    .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .mul(mul16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference product: interpret operands as plain integers and multiply.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input bit s);
    longint xv, yv, p;
    xv = longint'(x);
    yv = longint'(y);
    if (s && x[w-1]) xv = xv - (longint'(1) << w);
    if (s && y[w-1]) yv = yv - (longint'(1) << w);
    p = xv * yv;
    return 64'(p) & ((64'(1) << (2 * w)) - 64'(1));
  endfunction

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input bit s,
                      input logic [15:0] exp, input string tag);
    int n;
    @(negedge clk);
    check({tag, " in_ready"}, 64'(in_ready8), 64'(1));
    in_valid8 = 1'b1; a8 = x; b8 = y; in_signed8 = s; out_ready8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); in_signed8 = 1'($urandom);
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'(5));
    check({tag, " mul"}, 64'(mul8), 64'(exp));
  endtask

  task automatic run16(input logic [15:0] x, input logic [15:0] y, input bit s,
                       input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    in_valid16 = 1'b1; a16 = x; b16 = y; in_signed16 = s; out_ready16 = 1'b1;
    @(negedge clk);
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    n = 0;
    while (!out_valid16 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency16"}, 64'(n), 64'(9));
    check({tag, " mul16"}, 64'(mul16), 64'(exp));
  endtask

  initial begin
    logic [7:0]  x, y;
    logic [15:0] x16, y16;
    logic [15:0] held;
    bit          s, seen;
    int          n;

    rst_n = 1'b0; clear = 1'b0;
    in_valid8 = 1'b0; in_signed8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b0;
    in_valid16 = 1'b0; in_signed16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("rst in_ready", 64'(in_ready8), 64'(1));
    check("rst out_valid", 64'(out_valid8), 64'(0));
    check("rst mul", 64'(mul8), 64'(0));
    check("rst mul16", 64'(mul16), 64'(0));

    // Released: still idle, no spurious output even with out_ready asserted.
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    repeat (4) @(negedge clk);
    check("post-rst out_valid", 64'(out_valid8), 64'(0));
    check("post-rst in_ready", 64'(in_ready8), 64'(1));
    check("post-rst out_valid16", 64'(out_valid16), 64'(0));

    // Signed corners with hand-computed results.
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "s -128*-128");
    run8(8'h80, 8'h7F, 1'b1, 16'hC080, "s -128*127");
    run8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s -1*-1");
    run8(8'h7F, 8'hFF, 1'b1, 16'hFF81, "s 127*-1");

    // Unsigned extremes.
    run8(8'h00, 8'h00, 1'b0, 16'h0000, "u 0*0");
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u 255*255");
    run8(8'hFF, 8'h01, 1'b0, 16'h00FF, "u 255*1");
    run8(8'h80, 8'hFF, 1'b0, 16'h7F80, "u 128*255");

    // Random operands in both modes against the arithmetic model.
    for (int i = 0; i < 1500; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom);
      run8(x, y, s, 16'(ref_mul(8, {24'b0, x}, {24'b0, y}, s)), "rand8");
    end

    // Backpressure: product held in DONE for 10 cycles, new operands ignored.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'd200; b8 = 8'd77; in_signed8 = 1'b0; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("bp mul", 64'(mul8), 64'(15400));
    in_valid8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp out_valid held", 64'(out_valid8), 64'(1));
      check("bp mul held", 64'(mul8), 64'(15400));
      check("bp in_ready low", 64'(in_ready8), 64'(0));
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    check("bp consumed out_valid", 64'(out_valid8), 64'(0));
    check("bp consumed in_ready", 64'(in_ready8), 64'(1));

    // Abort on the third RUN cycle: nothing emitted, mul keeps the old product.
    held = mul8;
    in_valid8 = 1'b1; a8 = 8'd100; b8 = 8'd100; in_signed8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("abort in_ready", 64'(in_ready8), 64'(1));
    check("abort out_valid", 64'(out_valid8), 64'(0));
    check("abort mul kept", 64'(mul8), 64'(held));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid8) seen = 1'b1;
    end
    check("abort no output", 64'(seen), 64'(0));
    run8(8'd3, 8'd4, 1'b0, 16'd12, "after abort 3*4");

    // Async reset mid-RUN: immediate idle and reset values.
    @(negedge clk);
    in_valid8 = 1'b1; a8 = 8'd50; b8 = 8'd60; in_signed8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    check("mid-run in_ready low", 64'(in_ready8), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("arst run in_ready", 64'(in_ready8), 64'(1));
    check("arst run out_valid", 64'(out_valid8), 64'(0));
    check("arst run mul", 64'(mul8), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset while a product waits in DONE: out_valid drops without an edge.
    in_valid8 = 1'b1; a8 = 8'd7; b8 = 8'd11; out_ready8 = 1'b0;
    @(negedge clk);
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("pre-arst done mul", 64'(mul8), 64'(77));
    #2 rst_n = 1'b0;
    #1;
    check("arst done out_valid", 64'(out_valid8), 64'(0));
    check("arst done mul", 64'(mul8), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready8 = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid8) seen = 1'b1;
    end
    check("arst nothing emitted", 64'(seen), 64'(0));

    // Wide instance.
    run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u16 65535*65535");
    run16(16'h8000, 16'h8000, 1'b1, 32'h40000000, "s16 min*min");
    for (int i = 0; i < 200; i++) begin
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      s = 1'($urandom);
      run16(x16, y16, s, 32'(ref_mul(16, {16'b0, x16}, {16'b0, y16}, s)), "rand16");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
